pattern_field_buffer: RTL and testbench
=======================================

# pattern_field_buffer

Field-buffer responder sitting on the `pat` core's field port: holds 2^bufp_width pattern buffers of 2^fieldp_width fields, each buffer_width bits wide. The core reads the field at `{bufp, fieldp}` through `field_in` and writes `field_out` at `{bufp, fieldwp}`. A second, independent port transmits one selected buffer out as a valid/ready stream towards the pattern output stage. Writes to the buffer being streamed can optionally be locked out.

## Interface
- `bufp_width`, 3, buffer select width (8 buffers)
- `fieldp_width`, 5, field index width (32 fields per buffer)
- `buffer_width`, 8, field data width

- `clk` input 1 — single clock, all state on posedge
- `reset` input 1 — synchronous, active-low
- `bufp` input bufp_width — buffer selected by the core for read and write
- `fieldp` input fieldp_width — core read index
- `fieldwp` input fieldp_width — core write index
- `field_out` input buffer_width — core write data
- `field_we` input 1 — core write enable
- `field_in` output buffer_width — read data for `{bufp, fieldp}`
- `stream_start` input 1 — request to transmit buffer `stream_buf`
- `stream_buf` input bufp_width — buffer to transmit
- `stream_ready` input 1 — sink accepts current beat
- `stream_valid` output 1 — beat valid
- `stream_data` output buffer_width — beat data
- `stream_last` output 1 — final beat (field 2^fieldp_width−1)
- `busy` output 1 — stream in progress
- `done` output 1 — one-cycle pulse after final beat accepted
- `collision` output 1 — sticky write-lockout flag (see Configuration)

## Operation
- Storage: 2^(bufp_width+fieldp_width) words; address = `{buffer, field}`. Contents not cleared by reset.
- Core read: `field_in` = mem[{bufp, fieldp}], combinational (asynchronous read) so the core can latch it at the same edge.
- Core write: when `field_we`, mem[{bufp, fieldwp}] ← `field_out` at posedge. Same-cycle read of the same address returns the pre-edge value.
- Stream FSM, states IDLE and SEND:
  - IDLE: `stream_start`=1 at edge → latch `sbuf`←`stream_buf`, `idx`←0, `stream_data`←mem[{stream_buf,0}] (pre-edge contents), `stream_valid`←1, `busy`←1, go SEND.
  - SEND: `stream_valid`=1; `stream_data` held stable while `stream_ready`=0. On `stream_valid && stream_ready` at edge: if `idx`=max → `stream_valid`←0, `busy`←0, `done`←1 for one cycle, go IDLE; else `idx`←idx+1, `stream_data`←mem[{sbuf, idx+1}].
  - `stream_last` = SEND && `idx`=2^fieldp_width−1.
  - `stream_start` ignored in SEND (no queuing); `stream_start` in the same cycle `done` pulses is accepted (FSM is IDLE).
- Index counter is fieldp_width bits; no wrap beyond final beat, exactly 2^fieldp_width beats per transfer.

## Timing
- Reset (`reset`=0 at edge): FSM→IDLE, `stream_valid`=0, `stream_last`=0, `stream_data`=0, `busy`=0, `done`=0, `collision`=0. Memory retained. Reset mid-stream aborts the transfer with no `done`.
- Start to first valid beat: 1 cycle. Back-to-back with `stream_ready`=1: one beat per cycle, 32 beats, `done` the cycle after the last handshake.
- A core write to a field not yet loaded into `stream_data` is visible in the stream; the currently held beat never changes.

## Configuration
- `FIELDBUF_WRITE_LOCK_EN` defined: a core write with `busy`=1 and `bufp`=`sbuf` is dropped and `collision`←1 (sticky until reset). Writes to other buffers proceed.
- Not defined: all core writes proceed; `collision` tied 0.

## Test plan
- Write 0xA5 to {bufp=2, fieldwp=7}; next cycle set fieldp=7 → `field_in`=0xA5; same-edge read of that address returns old value.
- Fill buffer 3 with field i = i+0x10; start with stream_buf=3, ready=1 → 32 beats 0x10..0x2F on consecutive cycles, `stream_last` on 0x2F, `done` one cycle later, `busy` low.
- Same transfer with ready toggling 1,0,0,1… → data held during stalls, no beat lost or repeated, exactly 32 handshakes.
- `stream_start` with stream_buf=5 during buffer-3 transfer → ignored, buffer 3 completes unchanged.
- With lock macro: write buffer 3 field 20 during its stream → memory unchanged, `collision`=1; without macro → beat 20 carries new value, `collision`=0.
- Assert `reset`=0 at beat 10 → next cycle valid=0, busy=0, no done; buffer contents intact on re-stream.

Source files
------------

// File: rtl/pattern_field_buffer.sv
// -----------------------------------------------------------------------------
// pattern_field_buffer
//
// Field-buffer responder for the pattern core's field port. Holds
// 2^bufp_width pattern buffers of 2^fieldp_width fields each, buffer_width
// bits per field.
//
// Two independent access paths share one storage array:
//   * Core port: asynchronous read of {bufp, fieldp} on field_in, and a
//     synchronous write of field_out to {bufp, fieldwp} when field_we is high.
//   * Stream port: on stream_start, transmits every field of buffer
//     stream_buf in order as a valid/ready stream. There are exactly
//     2^fieldp_width beats, and done pulses for one cycle after the last
//     handshake.
//
// Optional feature (compile-time macro FIELDBUF_WRITE_LOCK_EN):
//   When the macro is defined, a core write to the buffer that is currently
//   being streamed is dropped and the sticky collision flag is set.
//   Writes to other buffers still proceed. Without the macro, every write
//   proceeds and collision is tied low.
//
// Ports:
//   clk          - single clock; all state changes on posedge
//   reset        - synchronous, active-low
//   bufp         - core buffer select (used for both read and write)
//   fieldp       - core read field index
//   fieldwp      - core write field index
//   field_out    - core write data
//   field_we     - core write enable
//   field_in     - core read data, mem[{bufp, fieldp}]
//   stream_start - request to transmit buffer stream_buf
//   stream_buf   - buffer to transmit
//   stream_ready - sink accepts the current beat
//   stream_valid - beat valid
//   stream_data  - beat data
//   stream_last  - final beat of the transfer
//   busy         - a transfer is in progress
//   done         - one-cycle pulse after the final beat is accepted
//   collision    - sticky write-lockout flag
// -----------------------------------------------------------------------------
module pattern_field_buffer #(
    parameter int bufp_width   = 3,
    parameter int fieldp_width = 5,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bufp_width-1:0]   bufp,
    input  logic [fieldp_width-1:0] fieldp,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    field_we,
    output logic [buffer_width-1:0] field_in,
    input  logic                    stream_start,
    input  logic [bufp_width-1:0]   stream_buf,
    input  logic                    stream_ready,
    output logic                    stream_valid,
    output logic [buffer_width-1:0] stream_data,
    output logic                    stream_last,
    output logic                    busy,
    output logic                    done,
    output logic                    collision
);

    localparam int ADDR_W = bufp_width + fieldp_width;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [fieldp_width-1:0] IDX_MAX = '1;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // Storage (not cleared by reset).
    logic [buffer_width-1:0] r_mem [DEPTH];

    state_t                  r_state;
    logic [bufp_width-1:0]   r_sbuf;
    logic [fieldp_width-1:0] r_idx;
    logic [buffer_width-1:0] r_data;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_lock_hit;
    logic                    w_write_en;
    logic [fieldp_width-1:0] w_idx_next;

    // A write is locked out only while a transfer of that same buffer runs.
`ifdef FIELDBUF_WRITE_LOCK_EN
    assign w_lock_hit = r_busy && (bufp == r_sbuf);
`else
    assign w_lock_hit = 1'b0;
`endif

    assign w_write_en = field_we && !w_lock_hit;
    assign w_idx_next = r_idx + 1'b1;

    // Core write port. Reads elsewhere in this module see pre-edge contents.
    always_ff @(posedge clk) begin
        if (w_write_en) begin
            r_mem[{bufp, fieldwp}] <= field_out;
        end
    end

    // Core read is asynchronous so the core can latch it at the same edge.
    assign field_in = r_mem[{bufp, fieldp}];

    // Stream FSM. The next beat is fetched at the handshake edge, so a core
    // write landing before that edge is visible. The beat being held is a
    // register and cannot change under the sink.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sbuf  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (stream_start) begin
                        r_sbuf  <= stream_buf;
                        r_idx   <= '0;
                        r_data  <= r_mem[{stream_buf, {fieldp_width{1'b0}}}];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    // stream_start is deliberately ignored here.
                    if (r_valid && stream_ready) begin
                        if (r_idx == IDX_MAX) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx  <= w_idx_next;
                            r_data <= r_mem[{r_sbuf, w_idx_next}];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIELDBUF_WRITE_LOCK_EN
    logic r_collision;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_collision <= 1'b0;
        end else if (field_we && w_lock_hit) begin
            r_collision <= 1'b1;
        end
    end

    assign collision = r_collision;
`else
    assign collision = 1'b0;
`endif

    assign stream_valid = r_valid;
    assign stream_data  = r_data;
    assign stream_last  = (r_state == S_SEND) && (r_idx == IDX_MAX);
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_pattern_field_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for pattern_field_buffer.
//
// The reference model is a flat array of field values indexed by
// buffer*32+field. It is updated whenever the bench performs a write that the
// rules say must land. Streams are checked beat by beat against that array.
// -----------------------------------------------------------------------------
module tb_pattern_field_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [4:0] fieldwp;
    logic [7:0] field_out;
    logic       field_we;
    logic [7:0] field_in;
    logic       stream_start;
    logic [2:0] stream_buf;
    logic       stream_ready;
    logic       stream_valid;
    logic [7:0] stream_data;
    logic       stream_last;
    logic       busy;
    logic       done;
    logic       collision;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] ref_mem [256];
    logic       exp_coll = 1'b0;

    always #5 clk = ~clk;

    pattern_field_buffer #(
        .bufp_width  (3),
        .fieldp_width(5),
        .buffer_width(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bufp        (bufp),
        .fieldp      (fieldp),
        .fieldwp     (fieldwp),
        .field_out   (field_out),
        .field_we    (field_we),
        .field_in    (field_in),
        .stream_start(stream_start),
        .stream_buf  (stream_buf),
        .stream_ready(stream_ready),
        .stream_valid(stream_valid),
        .stream_data (stream_data),
        .stream_last (stream_last),
        .busy        (busy),
        .done        (done),
        .collision   (collision)
    );

    // Every step ends 1 time unit after a rising edge, so registered outputs
    // are stable when sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes one field through the core port while idle, and mirrors the
    // write in the model.
    task automatic core_write(input int b, input int f, input logic [7:0] v);
        bufp      = 3'(b);
        fieldwp   = 5'(f);
        field_out = v;
        field_we  = 1'b1;
        tick();
        field_we  = 1'b0;
        ref_mem[b*32+f] = v;
        $display("[TB] write buf=%0d field=%0d data=%02h", b, f, v);
    endtask

    task automatic fill_buffer(input int b, input bit ramp);
        for (int i = 0; i < 32; i++) begin
            core_write(b, i, ramp ? 8'(i + 8'h10) : 8'($urandom_range(0, 255)));
        end
    endtask

    // Drives one complete transfer of buffer b and checks every beat.
    // mode 0: ready always high; mode 1: ready 1,0,0 repeating; mode 2: random.
    // Ends at the sample where done is expected to be high.
    task automatic run_stream(input int b, input int mode, input bit inj_start,
                              input bit inj_write, input string tag);
        int         beat = 0;
        int         cyc  = 0;
        int         hs   = 0;
        logic [7:0] newv;
        stream_buf   = 3'(b);
        stream_start = 1'b1;
        stream_ready = 1'b0;
        tick();
        stream_start = 1'b0;
        n_tests++;
        if (stream_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s start_latency: valid=%b busy=%b required 1/1",
                     tag, stream_valid, busy);
        end
        while (beat < 32 && cyc < 400) begin
            n_tests++;
            if (stream_valid !== 1'b1 || stream_data !== ref_mem[b*32+beat]) begin
                n_fail++;
                $display("[TB] FAIL %s beat%0d: valid=%b data=%02h required 1/%02h",
                         tag, beat, stream_valid, stream_data, ref_mem[b*32+beat]);
            end
            n_tests++;
            if (stream_last !== (beat == 31)) begin
                n_fail++;
                $display("[TB] FAIL %s last@beat%0d: got %b required %b",
                         tag, beat, stream_last, (beat == 31));
            end
            case (mode)
                0:       stream_ready = 1'b1;
                1:       stream_ready = (cyc % 3 == 0);
                default: stream_ready = 1'($urandom_range(0, 1));
            endcase
            if (inj_start && cyc == 3) begin
                stream_start = 1'b1;
                stream_buf   = 3'd5;
            end
            if (inj_write && cyc == 2) begin
                newv      = ref_mem[b*32+20] ^ 8'hFF;
                bufp      = 3'(b);
                fieldwp   = 5'd20;
                field_out = newv;
                field_we  = 1'b1;
`ifdef FIELDBUF_WRITE_LOCK_EN
                exp_coll = 1'b1;
`else
                ref_mem[b*32+20] = newv;
`endif
            end
            tick();
            stream_start = 1'b0;
            field_we     = 1'b0;
            if (stream_ready) begin
                $display("[TB] %s beat %0d handshake", tag, beat);
                beat++;
                hs++;
            end
            cyc++;
        end
        stream_ready = 1'b0;
        n_tests++;
        if (hs != 32) begin
            n_fail++;
            $display("[TB] FAIL %s handshakes: got %0d required 32 (timeout)", tag, hs);
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || stream_valid !== 1'b0 || stream_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s end: done=%b busy=%b valid=%b last=%b required 1/0/0/0",
                     tag, done, busy, stream_valid, stream_last);
        end
        n_tests++;
        if (collision !== exp_coll) begin
            n_fail++;
            $display("[TB] FAIL %s collision: got %b required %b", tag, collision, exp_coll);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        exp_coll = 1'b0;
        n_tests++;
        if (stream_valid !== 1'b0 || stream_last !== 1'b0 || stream_data !== 8'h00 ||
            busy !== 1'b0 || done !== 1'b0 || collision !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: v=%b l=%b d=%02h b=%b dn=%b c=%b required all 0",
                     stream_valid, stream_last, stream_data, busy, done, collision);
        end
        reset = 1'b1;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_core_rw();
        logic [7:0] old;
        fill_buffer(2, 1'b0);
        old = ref_mem[2*32+7];
        bufp      = 3'd2;
        fieldwp   = 5'd7;
        fieldp    = 5'd7;
        field_out = 8'hA5;
        field_we  = 1'b1;
        #1;
        n_tests++;
        if (field_in !== old) begin
            n_fail++;
            $display("[TB] FAIL same_edge_read: got %02h required %02h", field_in, old);
        end
        tick();
        field_we = 1'b0;
        ref_mem[2*32+7] = 8'hA5;
        #1;
        n_tests++;
        if (field_in !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL read_after_write: got %02h required a5", field_in);
        end
        for (int k = 0; k < 8; k++) begin
            int f = $urandom_range(0, 31);
            fieldp = 5'(f);
            #1;
            n_tests++;
            if (field_in !== ref_mem[2*32+f]) begin
                n_fail++;
                $display("[TB] FAIL rand_read f=%0d: got %02h required %02h",
                         f, field_in, ref_mem[2*32+f]);
            end
            $display("[TB] read buf=2 field=%0d data=%02h", f, field_in);
        end
        tick();
    endtask

    task automatic test_stream_full();
        fill_buffer(3, 1'b1);
        run_stream(3, 0, 1'b0, 1'b0, "full");
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL done_pulse_width: got %b required 0", done);
        end
    endtask

    task automatic test_stream_stall();
        run_stream(3, 1, 1'b0, 1'b0, "stall");
        tick();
        fill_buffer(6, 1'b0);
        run_stream(6, 2, 1'b0, 1'b0, "random");
        tick();
    endtask

    task automatic test_start_ignored();
        fill_buffer(5, 1'b0);
        run_stream(3, 0, 1'b1, 1'b0, "start_ignored");
        tick();
        n_tests++;
        if (busy !== 1'b0 || stream_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL no_queued_start: busy=%b valid=%b required 0/0",
                     busy, stream_valid);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(6, 0, 1'b0, 1'b0, "b2b_first");
        // stream_start is raised in the same cycle that done is high.
        run_stream(3, 2, 1'b0, 1'b0, "b2b_second");
        tick();
    endtask

    task automatic test_write_during_stream();
        run_stream(3, 0, 1'b0, 1'b1, "write_lock");
        tick();
        fieldp = 5'd20;
        bufp   = 3'd3;
        #1;
        n_tests++;
        if (field_in !== ref_mem[3*32+20]) begin
            n_fail++;
            $display("[TB] FAIL mem_after_stream_write: got %02h required %02h",
                     field_in, ref_mem[3*32+20]);
        end
        // A write to another buffer during a transfer must always land.
        bufp = 3'd1;
        fieldwp = 5'd4;
        field_out = 8'h3C;
        stream_buf = 3'd3;
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        field_we = 1'b1;
        tick();
        field_we = 1'b0;
        ref_mem[1*32+4] = 8'h3C;
        fieldp = 5'd4;
        #1;
        n_tests++;
        if (field_in !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL other_buf_write: got %02h required 3c", field_in);
        end
        stream_ready = 1'b1;
        for (int i = 0; i < 40 && busy; i++) tick();
        stream_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stream();
        int beat = 0;
        stream_buf   = 3'd3;
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        stream_ready = 1'b1;
        while (beat < 10) begin
            tick();
            beat++;
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        stream_ready = 1'b0;
        exp_coll = 1'b0;
        n_tests++;
        if (stream_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stream_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: valid=%b busy=%b done=%b data=%02h required 0/0/0/00",
                     stream_valid, busy, done, stream_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL post_reset_idle: done=%b busy=%b required 0/0", done, busy);
            end
        end
        $display("[TB] reset mid-stream at beat 10 applied");
        run_stream(3, 0, 1'b0, 1'b0, "restream");
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        bufp         = '0;
        fieldp       = '0;
        fieldwp      = '0;
        field_out    = '0;
        field_we     = 1'b0;
        stream_start = 1'b0;
        stream_buf   = '0;
        stream_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        #1;
        test_reset();
        test_core_rw();
        test_stream_full();
        test_stream_stall();
        test_start_ignored();
        test_back_to_back();
        test_write_during_stream();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
